// File: rtl/rr_and_pipe_sched_if.sv
// rtl/rr_and_pipe_sched_if.sv - client-side request/operand and result bundle for rr_and_pipe_sched
interface rr_and_pipe_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
);
  logic                en;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   a_bus;
  logic [NREQ*W-1:0]   b_bus;
  logic [NREQ-1:0]     gnt;
  logic [W-1:0]        q;
  logic                q_valid;
  logic [IDW-1:0]      q_id;
  logic                busy;
  logic [15:0]         op_cnt;

  modport master (
    output en, req, a_bus, b_bus,
    input  gnt, q, q_valid, q_id, busy, op_cnt
  );

  modport slave (
    input  en, req, a_bus, b_bus,
    output gnt, q, q_valid, q_id, busy, op_cnt
  );
endinterface

// File: rtl/rr_and_pipe_sched.sv
// rtl/rr_and_pipe_sched.sv - round-robin issue into a shared two-stage registered a&b pipeline
module rr_and_pipe_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  rr_and_pipe_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt, win, idx;
  logic [NREQ-1:0] elig;
  logic            any;
  logic [W-1:0]    s1;
  logic [IDW-1:0]  tag1;
  logic            v1;

  // A requester already holding gnt is masked so a held req cannot issue twice in a row.
  assign elig     = bus.req & ~bus.gnt;
  assign bus.busy = (state != IDLE);

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!any && elig[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
    ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.gnt     <= '0;
      bus.q       <= '0;
      bus.q_valid <= 1'b0;
      bus.q_id    <= '0;
      bus.op_cnt  <= '0;
      ptr         <= '0;
      s1          <= '0;
      tag1        <= '0;
      v1          <= 1'b0;
    end else if (bus.en) begin
      if (any) begin
        s1      <= bus.a_bus[win*W +: W] & bus.b_bus[win*W +: W];
        tag1    <= win;
        v1      <= 1'b1;
        bus.gnt <= NREQ'(1) << win;
        ptr     <= ptr_nxt;
      end else begin
        v1      <= 1'b0;
        bus.gnt <= '0;
      end
      bus.q       <= s1;
      bus.q_id    <= tag1;
      bus.q_valid <= v1;
      if (v1) bus.op_cnt <= bus.op_cnt + 16'd1;
    end else begin
      // Stall: pipeline contents freeze, only the pulse outputs are cleared.
      bus.gnt     <= '0;
      bus.q_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.en) begin
      case (state)
        IDLE:    if (any) state_nxt = RUN;
        RUN: begin
          if (any)     state_nxt = RUN;
          else if (v1) state_nxt = DRAIN;
          else         state_nxt = IDLE;
        end
        DRAIN: begin
          if (any)      state_nxt = RUN;
          else if (!v1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_and_pipe_sched.sv
// tb/tb_rr_and_pipe_sched.sv - scoreboard bench for rr_and_pipe_sched
module tb_rr_and_pipe_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_and_pipe_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();
  rr_and_pipe_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   q;
    bit             chk_id;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(int id, logic [W-1:0] v, bit chk_id = 1'b1);
    exp_t e;
    e.id     = IDW'(id);
    e.q      = v;
    e.chk_id = chk_id;
    sb.push_back(e);
  endtask

  task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b);
    bus.a_bus[i*W +: W] = a;
    bus.b_bus[i*W +: W] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    tick();
    tick();
    check("drain_empty", sb.size(), 0);
  endtask

  // Monitor: every q_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.q_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual_q=0x%0h actual_id=%0d required=none", bus.q, bus.q_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q", bus.q, e.q);
        if (e.chk_id) check("q_id", bus.q_id, e.id);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus.en    = 1'b1;
    bus.req   = '0;
    bus.a_bus = '0;
    bus.b_bus = '0;
    #12;
    check("rst_gnt", bus.gnt, 0);
    check("rst_q", bus.q, 0);
    check("rst_q_valid", bus.q_valid, 0);
    check("rst_q_id", bus.q_id, 0);
    check("rst_op_cnt", bus.op_cnt, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single op from requester 0
    set_op(0, 8'hF0, 8'h3C);
    push(0, 8'h30);
    bus.req = 4'b0001;
    tick();
    check("t1_gnt", bus.gnt, 4'b0001);
    check("t1_busy", bus.busy, 1);
    bus.req = 4'b0000;
    tick();
    check("t1_gnt_off", bus.gnt, 0);
    check("t1_op_cnt", bus.op_cnt, 1);
    tick();
    check("t1_busy_off", bus.busy, 0);
    wait_drain();

    // All four held: strict rotation starting at ptr=0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'hFF, 8'(8'h11 * (i + 1)));
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
    bus.req = 4'b1111;
    tick(); check("t2_gnt0", bus.gnt, 4'b0001);
    tick(); check("t2_gnt1", bus.gnt, 4'b0010);
    tick(); check("t2_gnt2", bus.gnt, 4'b0100);
    tick(); check("t2_gnt3", bus.gnt, 4'b1000);
    tick(); check("t2_gnt4", bus.gnt, 4'b0001);
    bus.req = 4'b0000;
    wait_drain();
    check("t2_op_cnt", bus.op_cnt, 5);

    // Pointer wrap: req2 alone leaves ptr=3, then req0 and req2 together
    do_reset();
    set_op(2, 8'h0F, 8'hFF);
    push(2, 8'h0F);
    bus.req = 4'b0100;
    tick(); check("t3_gnt_a", bus.gnt, 4'b0100);
    bus.req = 4'b0000;
    tick();
    set_op(0, 8'hAA, 8'hCC);
    set_op(2, 8'h5A, 8'h3C);
    push(0, 8'h88);
    push(2, 8'h18);
    bus.req = 4'b0101;
    tick(); check("t3_gnt_wrap", bus.gnt, 4'b0001);
    bus.req = 4'b0100;
    tick(); check("t3_gnt_next", bus.gnt, 4'b0100);
    bus.req = 4'b0000;
    wait_drain();
    check("t3_op_cnt", bus.op_cnt, 3);

    // Stall with an op captured and another request pending
    set_op(3, 8'h77, 8'h0F);
    set_op(0, 8'h81, 8'hFF);
    push(3, 8'h07);
    push(0, 8'h81);
    bus.req = 4'b1001;
    tick(); check("t4_gnt_first", bus.gnt, 4'b1000);
    bus.req = 4'b0001;
    bus.en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_stall_gnt", bus.gnt, 0);
      check("t4_stall_q_valid", bus.q_valid, 0);
    end
    bus.en = 1'b1;
    tick(); check("t4_gnt_resume", bus.gnt, 4'b0001);
    bus.req = 4'b0000;
    wait_drain();
    check("t4_op_cnt", bus.op_cnt, 5);

    // Async reset with both stages full
    do_reset();
    set_op(0, 8'h12, 8'hFF);
    set_op(1, 8'h34, 8'hFF);
    bus.req = 4'b0011;
    tick();
    tick();
    check("t5_inflight", bus.q_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    check("t5_gnt", bus.gnt, 0);
    check("t5_q", bus.q, 0);
    check("t5_q_valid", bus.q_valid, 0);
    check("t5_q_id", bus.q_id, 0);
    check("t5_op_cnt", bus.op_cnt, 0);
    check("t5_busy", bus.busy, 0);
    bus.req = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t5_op_cnt_after", bus.op_cnt, 0);

    // op_cnt wrap: 65535 ops from two alternating requesters, then one more
    do_reset();
    set_op(0, 8'h3C, 8'hFF);
    set_op(1, 8'h3C, 8'hFF);
    for (int i = 0; i < 65535; i++) push(0, 8'h3C, 1'b0);
    bus.req = 4'b0011;
    repeat (65535) @(posedge clk);
    #1;
    bus.req = 4'b0000;
    wait_drain();
    check("t6_op_cnt_max", bus.op_cnt, 16'hFFFF);
    set_op(2, 8'h81, 8'h0F);
    push(2, 8'h01);
    bus.req = 4'b0100;
    tick(); check("t6_gnt", bus.gnt, 4'b0100);
    bus.req = 4'b0000;
    wait_drain();
    check("t6_op_cnt_wrap", bus.op_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
